// File: rtl/stack_pop_unit.sv
// Read-side stack sequencer for POP/RET/RTI. It reads 1-3 words upward from SP,
// reports SP after each word, and reassembles pop data, the return PC and the CCR.
module stack_pop_unit #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 16,
    parameter int STACK_BASE = 2048,
    parameter int RD_LAT     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        pop_kind,
    input  logic [ADDR_W-1:0] sp_in,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              sp_load,
    output logic [ADDR_W-1:0] sp_next,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] pop_data,
    output logic [31:0]       pc_out,
    output logic [2:0]        ccr_out,
    output logic              ccr_load
);

    localparam logic [1:0] KIND_POP = 2'b00;
    localparam logic [1:0] KIND_RET = 2'b01;
    localparam logic [1:0] KIND_RTI = 2'b10;
    localparam logic [1:0] KIND_BAD = 2'b11;

    localparam int                WCNT_W    = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
    localparam logic [WCNT_W-1:0] WAIT_INIT = (WCNT_W)'((RD_LAT > 1) ? RD_LAT - 1 : 0);
    localparam logic [ADDR_W:0]   BASE_EXT  = (ADDR_W + 1)'(STACK_BASE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_RD,
        S_WAIT,
        S_CAP,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   sp_q, sp_d;
    logic [1:0]          kind_q, kind_d;
    logic [1:0]          n_q, n_d;
    logic [1:0]          idx_q, idx_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;

    // Words land here first so visible results only change on a completed pop.
    logic [DATA_W-1:0]   pop_sh_q, pop_sh_d;
    logic [15:0]         pc_hi_sh_q, pc_hi_sh_d;
    logic [15:0]         pc_lo_sh_q, pc_lo_sh_d;
    logic [2:0]          ccr_sh_q, ccr_sh_d;

    logic                mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                sp_load_q, sp_load_d;
    logic [ADDR_W-1:0]   sp_next_q, sp_next_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   pop_data_q, pop_data_d;
    logic [31:0]         pc_out_q, pc_out_d;
    logic [2:0]          ccr_out_q, ccr_out_d;
    logic                ccr_load_q, ccr_load_d;

    logic                enter_rd, enter_cap;
    logic [1:0]          n_chk;
    logic [ADDR_W:0]     sp_ext, avail;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path infers a latch.
        state_d    = state_q;
        sp_d       = sp_q;
        kind_d     = kind_q;
        n_d        = n_q;
        idx_d      = idx_q;
        wcnt_d     = wcnt_q;
        pop_sh_d   = pop_sh_q;
        pc_hi_sh_d = pc_hi_sh_q;
        pc_lo_sh_d = pc_lo_sh_q;
        ccr_sh_d   = ccr_sh_q;
        mem_rd_d   = 1'b0;
        mem_addr_d = '0;
        sp_load_d  = 1'b0;
        sp_next_d  = sp_next_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        ccr_load_d = 1'b0;
        pop_data_d = pop_data_q;
        pc_out_d   = pc_out_q;
        ccr_out_d  = ccr_out_q;
        enter_rd   = 1'b0;
        enter_cap  = 1'b0;

        case (kind_q)
            KIND_POP: n_chk = 2'd1;
            KIND_RET: n_chk = 2'd2;
            KIND_RTI: n_chk = 2'd3;
            default:  n_chk = 2'd0;
        endcase

        // An SP above the base means the stack is already past empty.
        sp_ext = {1'b0, sp_in};
        avail  = (sp_ext > BASE_EXT) ? '0 : (BASE_EXT - sp_ext);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    kind_d  = pop_kind;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                sp_d  = sp_in;
                n_d   = n_chk;
                idx_d = 2'd0;
                if (kind_q == KIND_BAD || avail < {{(ADDR_W - 1){1'b0}}, n_chk}) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    enter_rd = 1'b1;
                end
            end
            S_RD: begin
                if (RD_LAT > 1) begin
                    state_d = S_WAIT;
                    wcnt_d  = WAIT_INIT;
                end else begin
                    enter_cap = 1'b1;
                end
            end
            S_WAIT: begin
                if (wcnt_q <= (WCNT_W)'(1)) begin
                    enter_cap = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - (WCNT_W)'(1);
                end
            end
            S_CAP: begin
                // Pop order mirrors the push: CCR (RTI only), then PC high, then PC low.
                case (kind_q)
                    KIND_POP: pop_sh_d = mem_rdata;
                    KIND_RET: begin
                        if (idx_q == 2'd0) pc_hi_sh_d = mem_rdata[15:0];
                        else               pc_lo_sh_d = mem_rdata[15:0];
                    end
                    KIND_RTI: begin
                        if (idx_q == 2'd0)      ccr_sh_d   = mem_rdata[2:0];
                        else if (idx_q == 2'd1) pc_hi_sh_d = mem_rdata[15:0];
                        else                    pc_lo_sh_d = mem_rdata[15:0];
                    end
                    default: ;
                endcase
                if (idx_q == n_q - 2'd1) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    if (kind_q == KIND_POP) begin
                        pop_data_d = pop_sh_d;
                    end else begin
                        pc_out_d = {pc_hi_sh_d, pc_lo_sh_d};
                    end
                    if (kind_q == KIND_RTI) begin
                        ccr_out_d  = ccr_sh_d;
                        ccr_load_d = 1'b1;
                    end
                end else begin
                    idx_d    = idx_q + 2'd1;
                    enter_rd = 1'b1;
                end
            end
            S_DONE, S_ERR: state_d = S_IDLE;
            default:       state_d = S_IDLE;
        endcase

        if (enter_rd) begin
            state_d    = S_RD;
            mem_rd_d   = 1'b1;
            mem_addr_d = sp_d;
        end
        if (enter_cap) begin
            state_d   = S_CAP;
            sp_d      = sp_q + (ADDR_W)'(1);
            sp_load_d = 1'b1;
            sp_next_d = sp_q + (ADDR_W)'(1);
        end

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sp_q       <= '0;
            kind_q     <= '0;
            n_q        <= '0;
            idx_q      <= '0;
            wcnt_q     <= '0;
            pop_sh_q   <= '0;
            pc_hi_sh_q <= '0;
            pc_lo_sh_q <= '0;
            ccr_sh_q   <= '0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            sp_load_q  <= 1'b0;
            sp_next_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            pop_data_q <= '0;
            pc_out_q   <= '0;
            ccr_out_q  <= '0;
            ccr_load_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sp_q       <= sp_d;
            kind_q     <= kind_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            wcnt_q     <= wcnt_d;
            pop_sh_q   <= pop_sh_d;
            pc_hi_sh_q <= pc_hi_sh_d;
            pc_lo_sh_q <= pc_lo_sh_d;
            ccr_sh_q   <= ccr_sh_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            sp_load_q  <= sp_load_d;
            sp_next_q  <= sp_next_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            pop_data_q <= pop_data_d;
            pc_out_q   <= pc_out_d;
            ccr_out_q  <= ccr_out_d;
            ccr_load_q <= ccr_load_d;
        end
    end

    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign sp_load  = sp_load_q;
    assign sp_next  = sp_next_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign pop_data = pop_data_q;
    assign pc_out   = pc_out_q;
    assign ccr_out  = ccr_out_q;
    assign ccr_load = ccr_load_q;

endmodule

// File: tb/tb_stack_pop_unit.sv
// Directed bench for stack_pop_unit: one instance with RD_LAT=1 and one with
// RD_LAT=3, each fed by a behavioural memory with matching read latency.
module tb_stack_pop_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start1, start3;
    logic [1:0]  pop_kind;
    logic [11:0] sp_in;

    logic        mem_rd_1, sp_load_1, busy_1, done_1, err_1, ccr_load_1;
    logic [11:0] mem_addr_1, sp_next_1;
    logic [15:0] rdata_1, pop_data_1;
    logic [31:0] pc_out_1;
    logic [2:0]  ccr_out_1;

    logic        mem_rd_3, sp_load_3, busy_3, done_3, err_3, ccr_load_3;
    logic [11:0] mem_addr_3, sp_next_3;
    logic [15:0] rdata_3, pop_data_3;
    logic [31:0] pc_out_3;
    logic [2:0]  ccr_out_3;

    logic [15:0] mem [0:4095];
    logic [15:0] pipe3 [0:2];

    stack_pop_unit #(.ADDR_W(12), .DATA_W(16), .STACK_BASE(2048), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .start(start1), .pop_kind(pop_kind), .sp_in(sp_in),
        .mem_rd(mem_rd_1), .mem_addr(mem_addr_1), .mem_rdata(rdata_1),
        .sp_load(sp_load_1), .sp_next(sp_next_1), .busy(busy_1), .done(done_1), .err(err_1),
        .pop_data(pop_data_1), .pc_out(pc_out_1), .ccr_out(ccr_out_1), .ccr_load(ccr_load_1)
    );

    stack_pop_unit #(.ADDR_W(12), .DATA_W(16), .STACK_BASE(2048), .RD_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst), .start(start3), .pop_kind(pop_kind), .sp_in(sp_in),
        .mem_rd(mem_rd_3), .mem_addr(mem_addr_3), .mem_rdata(rdata_3),
        .sp_load(sp_load_3), .sp_next(sp_next_3), .busy(busy_3), .done(done_3), .err(err_3),
        .pop_data(pop_data_3), .pc_out(pc_out_3), .ccr_out(ccr_out_3), .ccr_load(ccr_load_3)
    );

    // Data is garbage unless a read was issued, so mistimed captures show up.
    always @(posedge clk) rdata_1 <= mem_rd_1 ? mem[mem_addr_1] : 16'hDEAD;
    always @(posedge clk) begin
        pipe3[0] <= mem_rd_3 ? mem[mem_addr_3] : 16'hDEAD;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign rdata_3 = pipe3[2];

    logic zero_1, zero_3;
    assign zero_1 = ~|{busy_1, mem_rd_1, mem_addr_1, sp_load_1, sp_next_1, done_1, err_1,
                       pop_data_1, pc_out_1, ccr_out_1, ccr_load_1};
    assign zero_3 = ~|{busy_3, mem_rd_3, mem_addr_3, sp_load_3, sp_next_3, done_3, err_3,
                       pop_data_3, pc_out_3, ccr_out_3, ccr_load_3};

    int checks = 0;
    int errors = 0;

    int          rd_n, spl_n, done_n, err_n, ccrl_n;
    int          done_cyc, err_cyc, ccrl_cyc;
    int          rd_cyc [8];
    int          spl_cyc [8];
    logic [11:0] rd_addr [8];
    logic [11:0] spl_val [8];
    logic        busy_first, snap_zero;

    task automatic launch(input bit lat3, input logic [1:0] kind, input logic [11:0] sp);
        @(negedge clk);
        pop_kind = kind;
        sp_in    = sp;
        if (lat3) start3 = 1'b1;
        else      start1 = 1'b1;
        @(negedge clk);
    endtask

    // Cycle j of the loop is cycle k+j, where k is the edge that sampled start.
    task automatic observe(input bit lat3, input int cycles, input int restart_at, input int rst_at);
        rd_n = 0; spl_n = 0; done_n = 0; err_n = 0; ccrl_n = 0;
        done_cyc = -1; err_cyc = -1; ccrl_cyc = -1; busy_first = 1'b0; snap_zero = 1'b0;
        for (int j = 1; j <= cycles; j++) begin
            logic        s_rd, s_spl, s_done, s_err, s_ccrl, s_busy;
            logic [11:0] s_addr, s_spn;
            s_rd   = lat3 ? mem_rd_3   : mem_rd_1;
            s_addr = lat3 ? mem_addr_3 : mem_addr_1;
            s_spl  = lat3 ? sp_load_3  : sp_load_1;
            s_spn  = lat3 ? sp_next_3  : sp_next_1;
            s_done = lat3 ? done_3     : done_1;
            s_err  = lat3 ? err_3      : err_1;
            s_ccrl = lat3 ? ccr_load_3 : ccr_load_1;
            s_busy = lat3 ? busy_3     : busy_1;
            if (j == 1) busy_first = s_busy;
            if (s_rd) begin
                if (rd_n < 8) begin rd_addr[rd_n] = s_addr; rd_cyc[rd_n] = j; end
                rd_n++;
            end
            if (s_spl) begin
                if (spl_n < 8) begin spl_val[spl_n] = s_spn; spl_cyc[spl_n] = j; end
                spl_n++;
            end
            if (s_done) begin if (done_cyc < 0) done_cyc = j; done_n++; end
            if (s_err)  begin if (err_cyc < 0)  err_cyc = j;  err_n++;  end
            if (s_ccrl) begin if (ccrl_cyc < 0) ccrl_cyc = j; ccrl_n++; end
            if (rst_at > 0 && j == rst_at + 1) snap_zero = lat3 ? zero_3 : zero_1;
            if (j == 2) sp_in = 12'h555;
            if (lat3) start3 = (j == restart_at);
            else      start1 = (j == restart_at);
            rst = (j == rst_at);
            @(negedge clk);
        end
        start1 = 1'b0;
        start3 = 1'b0;
        rst    = 1'b0;
    endtask

    task automatic test_reset;
        checks++; if (zero_1 !== 1'b1) begin errors++; $display("FAIL reset_outputs_lat1: got zero=%0b expected 1", zero_1); end
        checks++; if (zero_3 !== 1'b1) begin errors++; $display("FAIL reset_outputs_lat3: got zero=%0b expected 1", zero_3); end
    endtask

    task automatic test_pop;
        mem[2047] = 16'hBEEF;
        launch(1'b0, 2'b00, 12'd2047);
        observe(1'b0, 10, 0, 0);
        checks++; if (busy_first !== 1'b1) begin errors++; $display("FAIL pop_busy: got %0b expected 1", busy_first); end
        checks++; if (rd_n !== 1 || rd_cyc[0] !== 2 || rd_addr[0] !== 12'd2047) begin errors++;
            $display("FAIL pop_read: got n=%0d cyc=%0d addr=%0d expected n=1 cyc=2 addr=2047", rd_n, rd_cyc[0], rd_addr[0]); end
        checks++; if (spl_n !== 1 || spl_cyc[0] !== 3 || spl_val[0] !== 12'd2048) begin errors++;
            $display("FAIL pop_sp: got n=%0d cyc=%0d sp=%0d expected n=1 cyc=3 sp=2048", spl_n, spl_cyc[0], spl_val[0]); end
        checks++; if (done_n !== 1 || done_cyc !== 4 || err_n !== 0 || ccrl_n !== 0) begin errors++;
            $display("FAIL pop_done: got done=%0d@%0d err=%0d ccrl=%0d expected 1@4 0 0", done_n, done_cyc, err_n, ccrl_n); end
        checks++; if (pop_data_1 !== 16'hBEEF) begin errors++; $display("FAIL pop_data: got %h expected beef", pop_data_1); end

        mem[2040] = 16'h1234;
        launch(1'b0, 2'b00, 12'd2040);
        observe(1'b0, 8, 0, 0);
        checks++; if (rd_addr[0] !== 12'd2040 || spl_val[0] !== 12'd2041 || done_cyc !== 4) begin errors++;
            $display("FAIL pop2_seq: got addr=%0d sp=%0d done@%0d expected 2040 2041 4", rd_addr[0], spl_val[0], done_cyc); end
        checks++; if (pop_data_1 !== 16'h1234) begin errors++; $display("FAIL pop2_data: got %h expected 1234", pop_data_1); end
    endtask

    task automatic test_ret;
        mem[2046] = 16'h0001;
        mem[2047] = 16'h2345;
        launch(1'b0, 2'b01, 12'd2046);
        observe(1'b0, 10, 0, 0);
        checks++; if (rd_n !== 2 || rd_addr[0] !== 12'd2046 || rd_addr[1] !== 12'd2047 || rd_cyc[0] !== 2 || rd_cyc[1] !== 4) begin errors++;
            $display("FAIL ret_reads: got n=%0d %0d@%0d %0d@%0d expected 2 2046@2 2047@4", rd_n, rd_addr[0], rd_cyc[0], rd_addr[1], rd_cyc[1]); end
        checks++; if (spl_n !== 2 || spl_val[0] !== 12'd2047 || spl_val[1] !== 12'd2048 || spl_cyc[0] !== 3 || spl_cyc[1] !== 5) begin errors++;
            $display("FAIL ret_sp: got n=%0d %0d@%0d %0d@%0d expected 2 2047@3 2048@5", spl_n, spl_val[0], spl_cyc[0], spl_val[1], spl_cyc[1]); end
        checks++; if (done_n !== 1 || done_cyc !== 6 || ccrl_n !== 0) begin errors++;
            $display("FAIL ret_done: got %0d@%0d ccrl=%0d expected 1@6 0", done_n, done_cyc, ccrl_n); end
        checks++; if (pc_out_1 !== 32'h0001_2345 || pop_data_1 !== 16'h1234) begin errors++;
            $display("FAIL ret_result: got pc=%h pop=%h expected 00012345 1234", pc_out_1, pop_data_1); end
    endtask

    task automatic test_rti;
        mem[2045] = 16'h0005;
        mem[2046] = 16'h0000;
        mem[2047] = 16'h0010;
        launch(1'b0, 2'b10, 12'd2045);
        observe(1'b0, 12, 0, 0);
        checks++; if (rd_n !== 3 || rd_addr[0] !== 12'd2045 || rd_addr[2] !== 12'd2047 || rd_cyc[2] !== 6) begin errors++;
            $display("FAIL rti_reads: got n=%0d first=%0d last=%0d@%0d expected 3 2045 2047@6", rd_n, rd_addr[0], rd_addr[2], rd_cyc[2]); end
        checks++; if (spl_n !== 3 || spl_val[2] !== 12'd2048) begin errors++;
            $display("FAIL rti_sp: got n=%0d final=%0d expected 3 2048", spl_n, spl_val[2]); end
        checks++; if (done_cyc !== 8 || ccrl_n !== 1 || ccrl_cyc !== 8) begin errors++;
            $display("FAIL rti_done: got done@%0d ccrl=%0d@%0d expected 8 1@8", done_cyc, ccrl_n, ccrl_cyc); end
        checks++; if (ccr_out_1 !== 3'b101 || pc_out_1 !== 32'h0000_0010) begin errors++;
            $display("FAIL rti_result: got ccr=%b pc=%h expected 101 00000010", ccr_out_1, pc_out_1); end
    endtask

    task automatic test_errors;
        logic [1:0]  e_kind [5] = '{2'b01, 2'b00, 2'b11, 2'b10, 2'b00};
        logic [11:0] e_sp   [5] = '{12'd2047, 12'd2048, 12'd2000, 12'd2046, 12'd2049};
        for (int t = 0; t < 5; t++) begin
            launch(1'b0, e_kind[t], e_sp[t]);
            observe(1'b0, 8, 0, 0);
            checks++; if (err_n !== 1 || err_cyc !== 2) begin errors++;
                $display("FAIL err_pulse[%0d]: got %0d@%0d expected 1@2", t, err_n, err_cyc); end
            checks++; if (rd_n !== 0 || spl_n !== 0 || done_n !== 0) begin errors++;
                $display("FAIL err_side[%0d]: got rd=%0d spl=%0d done=%0d expected 0 0 0", t, rd_n, spl_n, done_n); end
            checks++; if (pc_out_1 !== 32'h0000_0010 || ccr_out_1 !== 3'b101 || pop_data_1 !== 16'h1234) begin errors++;
                $display("FAIL err_hold[%0d]: got pc=%h ccr=%b pop=%h expected 00000010 101 1234", t, pc_out_1, ccr_out_1, pop_data_1); end
        end
    endtask

    task automatic test_back_to_back;
        mem[2046] = 16'hAAAA;
        mem[2047] = 16'h5555;
        launch(1'b0, 2'b01, 12'd2046);
        observe(1'b0, 14, 3, 0);
        checks++; if (done_n !== 1 || rd_n !== 2 || err_n !== 0) begin errors++;
            $display("FAIL busy_start_ignored: got done=%0d rd=%0d err=%0d expected 1 2 0", done_n, rd_n, err_n); end
        checks++; if (pc_out_1 !== 32'hAAAA_5555) begin errors++; $display("FAIL busy_start_pc: got %h expected aaaa5555", pc_out_1); end
    endtask

    task automatic test_reset_mid;
        mem[2045] = 16'h0003;
        mem[2046] = 16'h1111;
        mem[2047] = 16'h2222;
        launch(1'b0, 2'b10, 12'd2045);
        observe(1'b0, 12, 0, 4);
        checks++; if (rd_n !== 2 || rd_cyc[1] !== 4) begin errors++;
            $display("FAIL abort_reads: got n=%0d second@%0d expected 2 @4", rd_n, rd_cyc[1]); end
        checks++; if (snap_zero !== 1'b1) begin errors++; $display("FAIL abort_outputs: got zero=%0b expected 1", snap_zero); end
        checks++; if (done_n !== 0 || spl_n !== 1 || ccrl_n !== 0) begin errors++;
            $display("FAIL abort_pulses: got done=%0d spl=%0d ccrl=%0d expected 0 1 0", done_n, spl_n, ccrl_n); end
    endtask

    task automatic test_rd_lat3;
        mem[2046] = 16'h0001;
        mem[2047] = 16'h2345;
        launch(1'b1, 2'b01, 12'd2046);
        observe(1'b1, 14, 0, 0);
        checks++; if (rd_n !== 2 || rd_cyc[0] !== 2 || rd_cyc[1] !== 6 || rd_addr[1] !== 12'd2047) begin errors++;
            $display("FAIL lat3_reads: got n=%0d @%0d @%0d addr=%0d expected 2 @2 @6 2047", rd_n, rd_cyc[0], rd_cyc[1], rd_addr[1]); end
        checks++; if (spl_n !== 2 || spl_cyc[0] !== 5 || spl_cyc[1] !== 9 || spl_val[1] !== 12'd2048) begin errors++;
            $display("FAIL lat3_sp: got n=%0d @%0d @%0d sp=%0d expected 2 @5 @9 2048", spl_n, spl_cyc[0], spl_cyc[1], spl_val[1]); end
        checks++; if (done_n !== 1 || done_cyc !== 10) begin errors++;
            $display("FAIL lat3_done: got %0d@%0d expected 1@10", done_n, done_cyc); end
        checks++; if (pc_out_3 !== 32'h0001_2345) begin errors++; $display("FAIL lat3_pc: got %h expected 00012345", pc_out_3); end
    endtask

    initial begin
        rst = 1'b1; start1 = 1'b0; start3 = 1'b0; pop_kind = 2'b00; sp_in = '0;
        repeat (3) @(negedge clk);
        test_reset;
        rst = 1'b0;
        test_pop;
        test_ret;
        test_rti;
        test_errors;
        test_back_to_back;
        test_reset_mid;
        test_rd_lat3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
